// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-7-segment font for the scanned display.
// Segment vectors are {a,b,c,d,e,f,g}, active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    hex_to_seg = SEG_OFF;
    case (nibble)
      4'h0: hex_to_seg = 7'b0000001;
      4'h1: hex_to_seg = 7'b1001111;
      4'h2: hex_to_seg = 7'b0010010;
      4'h3: hex_to_seg = 7'b0000110;
      4'h4: hex_to_seg = 7'b1001100;
      4'h5: hex_to_seg = 7'b0100100;
      4'h6: hex_to_seg = 7'b0100000;
      4'h7: hex_to_seg = 7'b0001111;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0001100;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b1100000;
      4'hC: hex_to_seg = 7'b0110001;
      4'hD: hex_to_seg = 7'b1000010;
      4'hE: hex_to_seg = 7'b0110000;
      4'hF: hex_to_seg = 7'b0111000;
      default: hex_to_seg = SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/seg7_hex_font.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_font
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-coherent snapshot,
// per-digit enable/dp/blink and dead time at the start of every digit slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS   = 4,
  parameter  int REFRESH_DIV  = 100000,
  parameter  int GHOST_CYCLES = 500,
  parameter  int BLINK_FRAMES = 64,
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [IDX_W-1:0]        scan_idx,
  output logic                    frame_start
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GHOST_END = CNT_W'(GHOST_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [BLK_W-1:0]        blink_cnt;
  logic                    blink_phase;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_den;
  logic [NUM_DIGITS-1:0]   snap_blink;

  logic                    slot_end;
  logic                    frame_end;
  logic [3:0]              cur_nibble;
  logic                    cur_dp;
  logic                    cur_den;
  logic                    cur_blink;
  logic                    visible;
  logic [6:0]              cur_seg;
  logic [NUM_DIGITS-1:0]   anode_next;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Slot counter and digit index keep running even while the display is disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Inputs are latched only at the frame boundary so a frame never mixes old and new data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_den    <= '0;
      snap_blink  <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      snap_digits <= digits;
      snap_dp     <= dp_in;
      snap_den    <= digit_en;
      snap_blink  <= blink_en;
      if (blink_cnt == BLK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end
    end
  end

  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    cur_den    = 1'b0;
    cur_blink  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nibble = snap_digits[4*i +: 4];
        cur_dp     = snap_dp[i];
        cur_den    = snap_den[i];
        cur_blink  = snap_blink[i];
      end
    end
  end

  seg7_hex_font u_font (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // Dead time at the start of each slot lets the previous digit's anode fully turn off
  always_comb begin
    visible    = en && cur_den && !(blink_phase && cur_blink) && (cnt >= GHOST_END);
    anode_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      anode_next[i] = !(visible && (idx == IDX_W'(i)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      anode       <= '1;
      scan_idx    <= '0;
      frame_start <= 1'b0;
    end else begin
      seg         <= cur_seg;
      dp          <= ~cur_dp;
      anode       <= anode_next;
      scan_idx    <= idx;
      frame_start <= (cnt == '0) && (idx == '0);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-count reference model predicts
// every output sample, a monitor compares them on the falling edge.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int GH    = 2;
  localparam int BF    = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [15:0] digits = 16'h1234;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  blink_en = 4'h0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  anode;
  logic [1:0]  scan_idx;
  logic        frame_start;

  int checks = 0;
  int failures = 0;
  int popped = 0;
  int mt = 0;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];

  logic [15:0] snap_digits = '0;
  logic [3:0]  snap_dp = '0;
  logic [3:0]  snap_den = '0;
  logic [3:0]  snap_blink = '0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .GHOST_CYCLES (GH),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .digits      (digits),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .blink_en    (blink_en),
    .seg         (seg),
    .dp          (dp),
    .anode       (anode),
    .scan_idx    (scan_idx),
    .frame_start (frame_start)
  );

  function automatic logic [6:0] font_ref(input int v);
    case (v)
      0:  return 7'b0000001;
      1:  return 7'b1001111;
      2:  return 7'b0010010;
      3:  return 7'b0000110;
      4:  return 7'b1001100;
      5:  return 7'b0100100;
      6:  return 7'b0100000;
      7:  return 7'b0001111;
      8:  return 7'b0000000;
      9:  return 7'b0001100;
      10: return 7'b0001000;
      11: return 7'b1100000;
      12: return 7'b0110001;
      13: return 7'b1000010;
      14: return 7'b0110000;
      15: return 7'b0111000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, want, $time);
    end
  endtask

  task automatic applyStimulus(input logic e_in, input logic [15:0] d, input logic [3:0] dpv,
                               input logic [3:0] den, input logic [3:0] blk, input int cycles);
    en       = e_in;
    digits   = d;
    dp_in    = dpv;
    digit_en = den;
    blink_en = blk;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Waits (bounded) until the model's elapsed-cycle count hits a slot/frame position
  task automatic waitTick(input int modulus, input int target);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (!found) begin
        if (mt % modulus == target) found = 1'b1;
        else @(negedge clk);
      end
    end
    checkOutput("align_timeout", 32'(found), 32'd1);
  endtask

  // Reference model: position in the scan follows purely from cycles since reset
  initial begin
    exp_t e;
    int cnt, slot, idx, frame, phase, nib;
    logic vis;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mt          = 0;
        snap_digits = '0;
        snap_dp     = '0;
        snap_den    = '0;
        snap_blink  = '0;
        exp_q.delete();
      end else begin
        cnt   = mt % RD;
        slot  = mt / RD;
        idx   = slot % ND;
        frame = slot / ND;
        phase = (frame / BF) % 2;
        nib   = int'((snap_digits >> (4 * idx)) & 16'hF);
        vis   = en && snap_den[idx] && !(phase == 1 && snap_blink[idx]) && (cnt >= GH);
        e.anode = vis ? ~(4'b0001 << idx) : 4'b1111;
        e.seg   = font_ref(nib);
        e.dp    = ~snap_dp[idx];
        e.idx   = 2'(idx);
        e.fs    = (cnt == 0) && (idx == 0);
        exp_q.push_back(e);
        if (cnt == RD - 1 && idx == ND - 1) begin
          snap_digits = digits;
          snap_dp     = dp_in;
          snap_den    = digit_en;
          snap_blink  = blink_en;
        end
        mt++;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checkOutput("reset_anode", 32'(anode), 32'hF);
        checkOutput("reset_seg", 32'(seg), 32'h7F);
        checkOutput("reset_dp", 32'(dp), 32'd1);
        checkOutput("reset_scan_idx", 32'(scan_idx), 32'd0);
        checkOutput("reset_frame_start", 32'(frame_start), 32'd0);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        popped++;
        checkOutput("anode", 32'(anode), 32'(e.anode));
        checkOutput("seg", 32'(seg), 32'(e.seg));
        checkOutput("dp", 32'(dp), 32'(e.dp));
        checkOutput("scan_idx", 32'(scan_idx), 32'(e.idx));
        checkOutput("frame_start", 32'(frame_start), 32'(e.fs));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lit, fs_cnt;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Frame 0 is dark, later frames show 1234 with 6 of 8 cycles lit per slot
    repeat (2 * FRAME) @(negedge clk);
    lit = 0;
    fs_cnt = 0;
    repeat (FRAME) begin
      @(negedge clk);
      if (anode != 4'hF) lit++;
      if (frame_start) fs_cnt++;
    end
    checkOutput("lit_cycles_per_frame", 32'(lit), 32'd24);
    checkOutput("frame_start_per_frame", 32'(fs_cnt), 32'd1);

    waitTick(FRAME, FRAME / 2);
    applyStimulus(1'b1, 16'hABCD, 4'h0, 4'hF, 4'h0, 2 * FRAME);

    applyStimulus(1'b1, 16'hABCD, 4'h0, 4'hF, 4'b0001, 5 * FRAME);
    fs_cnt = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (frame_start) fs_cnt++;
    end
    checkOutput("frame_start_per_64", 32'(fs_cnt), 32'd2);

    applyStimulus(1'b1, 16'h5678, 4'b0010, 4'b0011, 4'h0, 2 * FRAME);

    applyStimulus(1'b1, 16'h9E0F, 4'h0, 4'hF, 4'h0, 2 * FRAME);
    waitTick(RD, 3);
    applyStimulus(1'b0, 16'h9E0F, 4'h0, 4'hF, 4'h0, 5);
    applyStimulus(1'b1, 16'h9E0F, 4'h0, 4'hF, 4'h0, FRAME);

    waitTick(FRAME, 2 * RD + 5);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_anode", 32'(anode), 32'hF);
    checkOutput("async_reset_seg", 32'(seg), 32'h7F);
    checkOutput("async_reset_scan_idx", 32'(scan_idx), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 7) == 0) doReset(2);
      applyStimulus($urandom_range(0, 9) != 0, 16'($urandom), 4'($urandom), 4'($urandom),
                    4'($urandom), int'($urandom_range(1, 48)));
    end

    checkOutput("scoreboard_samples", 32'(popped >= 400), 32'd1);
    checkOutput("queue_drained", 32'(exp_q.size() <= 1), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
